// File: rtl/morse_capture.sv
// Morse key capture: synchronises and debounces a raw key, classifies each
// press as a dot or a dash by its length, and packs up to four symbols into
// an 8-bit letter code that is published after a long enough release.
module morse_capture #(
  parameter int CNT_W        = 24,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int DOT_MAX      = 10000000,
  parameter int LETTER_GAP   = 30000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [7:0] morse_array,
  output logic       char_valid,
  output logic       overflow
);

  // The gap counter must be able to hold LETTER_GAP even when CNT_W is too
  // narrow for it (the default LETTER_GAP needs 25 bits).
  localparam int LG_W  = $clog2(LETTER_GAP + 1);
  localparam int GAP_W = (CNT_W > LG_W) ? CNT_W : LG_W;
  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

  localparam logic [CNT_W-1:0] DOT_TH = CNT_W'(DOT_MAX);
  localparam logic [GAP_W-1:0] GAP_TH = GAP_W'(LETTER_GAP);
  localparam logic [DB_W-1:0]  DB_TH  = DB_W'(DEBOUNCE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic             key_meta, key_sync, key_db;
  logic [DB_W-1:0]  db_cnt;
  logic [CNT_W-1:0] press_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [5:0]       shreg_hi;
  logic [7:0]       shreg;
  logic [2:0]       sym_cnt;
  logic             ovf_pend;
  logic [1:0]       sym;

  logic start_press, end_press, gap_done;

  assign shreg_hi = shreg[5:0];
  assign sym      = (press_cnt < DOT_TH) ? 2'b01 : 2'b10;

  // Two-flop synchroniser followed by a consecutive-cycle debounce filter.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      key_db   <= 1'b0;
      db_cnt   <= '0;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
      if (key_sync != key_db) begin
        if (db_cnt == DB_TH) begin
          key_db <= key_sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and datapath strobes.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    start_press = 1'b0;
    end_press   = 1'b0;
    gap_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (key_db) begin
          start_press = 1'b1;
          state_next  = PRESS;
        end
      end
      PRESS: begin
        if (!key_db) begin
          end_press  = 1'b1;
          state_next = GAP;
        end
      end
      GAP: begin
        // A completed gap wins even if the key has just gone down again.
        if (gap_cnt == GAP_TH) begin
          gap_done   = 1'b1;
          state_next = IDLE;
        end else if (key_db) begin
          start_press = 1'b1;
          state_next  = PRESS;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Press/gap counters, symbol shift register and letter publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      press_cnt   <= '0;
      gap_cnt     <= '0;
      shreg       <= '0;
      sym_cnt     <= '0;
      ovf_pend    <= 1'b0;
      morse_array <= '0;
      char_valid  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      overflow   <= 1'b0;

      if (start_press) begin
        press_cnt <= CNT_W'(1);
      end else if (state == PRESS && key_db && press_cnt != '1) begin
        press_cnt <= press_cnt + 1'b1;
      end

      if (end_press) begin
        gap_cnt <= GAP_W'(1);
        if (sym_cnt == 3'd4) begin
          ovf_pend <= 1'b1;
        end else begin
          shreg   <= {shreg_hi, sym};
          sym_cnt <= sym_cnt + 1'b1;
        end
      end else if (state == GAP && !gap_done && !key_db) begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (gap_done) begin
        if (ovf_pend) begin
          overflow <= 1'b1;
        end else begin
          morse_array <= shreg;
          char_valid  <= 1'b1;
        end
        shreg    <= '0;
        sym_cnt  <= '0;
        ovf_pend <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_capture.sv
// Testbench for morse_capture: a run-length letter model predicts the outputs
// on every cycle, and directed letters pin the model with literal codes.
module tb_morse_capture;

  localparam int CNT_W = 8;
  localparam int DB    = 2;
  localparam int DOT   = 10;
  localparam int LG    = 30;
  localparam int SAT   = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic [7:0] morse_array;
  logic       char_valid;
  logic       overflow;

  morse_capture #(
    .CNT_W(CNT_W), .DEBOUNCE_CYC(DB), .DOT_MAX(DOT), .LETTER_GAP(LG)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .morse_array(morse_array), .char_valid(char_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int cv_count = 0;
  int ov_count = 0;
  int last_cv_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        started = 1'b0;
  bit        m_meta, m_sync, m_db;
  bit        shist[$];
  bit        pressing, in_gap, ovf;
  int        press_len, gap_len;
  bit        dash_q[$];
  logic [7:0] exp_ma = '0;
  bit        exp_cv, exp_ov;

  // Letter code: each symbol is a base-4 digit (dot 1, dash 2), first symbol
  // most significant.
  function automatic logic [7:0] pack(input bit q[$]);
    int r = 0;
    foreach (q[i]) r = r * 4 + (q[i] ? 2 : 1);
    return 8'(r);
  endfunction

  task automatic model_step();
    bit v;
    bit all_diff;
    exp_cv = 1'b0;
    exp_ov = 1'b0;
    if (rst) begin
      m_meta = 1'b0; m_sync = 1'b0; m_db = 1'b0;
      shist.delete();
      repeat (DB) shist.push_back(1'b0);
      pressing = 1'b0; in_gap = 1'b0; ovf = 1'b0;
      press_len = 0; gap_len = 0;
      dash_q.delete();
      exp_ma = '0;
      return;
    end
    v = m_db;
    if (in_gap && gap_len == LG) begin
      if (ovf) exp_ov = 1'b1;
      else begin
        exp_ma = pack(dash_q);
        exp_cv = 1'b1;
      end
      dash_q.delete();
      ovf = 1'b0;
      in_gap = 1'b0;
    end else if (v) begin
      if (!pressing) begin
        pressing = 1'b1; press_len = 1; in_gap = 1'b0;
      end else if (press_len < SAT) begin
        press_len++;
      end
    end else if (pressing) begin
      pressing = 1'b0;
      if (dash_q.size() == 4) ovf = 1'b1;
      else dash_q.push_back(press_len >= DOT);
      in_gap = 1'b1;
      gap_len = 1;
    end else if (in_gap) begin
      gap_len++;
    end
    // Debounced level flips once the last DB synchronised samples all disagree.
    shist.push_back(m_sync);
    void'(shist.pop_front());
    all_diff = 1'b1;
    foreach (shist[i]) if (shist[i] == m_db) all_diff = 1'b0;
    if (all_diff) m_db = ~m_db;
    m_sync = m_meta;
    m_meta = key_in;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
    started = 1'b1;
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  initial forever begin
    @(negedge clk);
    if (started) begin
      check($sformatf("outputs@%0d", cyc), {22'd0, char_valid, overflow, morse_array},
            {22'd0, exp_cv, exp_ov, exp_ma});
      if (char_valid === 1'b1) begin
        cv_count++;
        last_cv_cyc = cyc;
      end
      if (overflow === 1'b1) ov_count++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int c0, cv0, ov0;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_morse_array", morse_array, 8'h00);
    check("reset_char_valid", char_valid, 1'b0);

    // E: one short press; char_valid 40 cycles after key goes down.
    c0 = cyc; cv0 = cv_count;
    hold(1, 5); hold(0, 40);
    check("E_code", morse_array, 8'b00000001);
    check("E_pulses", cv_count - cv0, 1);
    check("E_latency", last_cv_cyc - c0, 40);

    // A: dot then dash.
    cv0 = cv_count;
    hold(1, 4); hold(0, 8); hold(1, 15); hold(0, 40);
    check("A_code", morse_array, 8'b00000110);
    check("A_pulses", cv_count - cv0, 1);

    // Exactly DOT_MAX cycles is a dash, one less is a dot.
    hold(1, 10); hold(0, 40);
    check("T_boundary", morse_array, 8'b00000010);
    hold(1, 9); hold(0, 40);
    check("dot_boundary", morse_array, 8'b00000001);

    // Five dots: letter discarded with an overflow pulse.
    cv0 = cv_count; ov0 = ov_count;
    for (int i = 0; i < 4; i++) begin
      hold(1, 4); hold(0, 8);
    end
    hold(1, 4); hold(0, 40);
    check("ovf_pulses", ov_count - ov0, 1);
    check("ovf_no_char", cv_count - cv0, 0);
    check("ovf_keeps_code", morse_array, 8'b00000001);

    // Single-cycle glitch is filtered out.
    cv0 = cv_count; ov0 = ov_count;
    hold(1, 1); hold(0, 40);
    check("glitch_no_char", cv_count - cv0, 0);
    check("glitch_no_ovf", ov_count - ov0, 0);

    // Gap of 29 keeps the letter open: I = dot dot.
    cv0 = cv_count;
    hold(1, 4); hold(0, 29); hold(1, 4); hold(0, 40);
    check("gap29_code", morse_array, 8'b00000101);
    check("gap29_pulses", cv_count - cv0, 1);

    // Gap of 30 closes the letter: E then T.
    cv0 = cv_count;
    hold(1, 4); hold(0, 30); hold(1, 12); hold(0, 40);
    check("gap30_pulses", cv_count - cv0, 2);
    check("gap30_code", morse_array, 8'b00000010);

    // Reset during a gap with two symbols pending.
    cv0 = cv_count; ov0 = ov_count;
    hold(1, 4); hold(0, 8); hold(1, 4); hold(0, 10);
    rst = 1'b1; hold(0, 3); rst = 1'b0;
    check("rst_gap_code", morse_array, 8'h00);
    check("rst_gap_no_pulse", cv_count - cv0 + ov_count - ov0, 0);
    hold(1, 4); hold(0, 40);
    check("rst_gap_after", morse_array, 8'b00000001);

    // Reset mid-press with the key still held: re-debounced as a new dot.
    cv0 = cv_count;
    hold(1, 6);
    rst = 1'b1; hold(1, 2); rst = 1'b0;
    hold(1, 5); hold(0, 40);
    check("rst_press_code", morse_array, 8'b00000001);
    check("rst_press_pulses", cv_count - cv0, 1);

    // Long press saturates and stays a dash.
    hold(1, 300); hold(0, 40);
    check("saturate_dash", morse_array, 8'b00000010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
